aes_dec_arbiter: RTL

Round-robin scheduler that shares one AESDecryptPipe instance among NUM_REQ block-decrypt requesters. Accepts 128-bit ciphertext blocks over per-requester valid/ready handshakes and issues at most one block per cycle to the pipe. Tags each issued block with its requester ID and steers each plaintext result back to the owner. Provides flush/drain sequencing for key changes.

---
 rtl/aes_dec_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aes_dec_arbiter.sv
// Round-robin scheduler sharing one AES decrypt pipe among NUM_REQ requesters, with result steering and flush/drain.
// Optional macro AES_ARB_BURST_EN lets a requester keep the grant for up to MAX_BURST consecutive accepts.
module aes_dec_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int PIPE_LAT  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*128-1:0]  req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [127:0]            resp_data,
  output logic                    pipe_ready,
  output logic [127:0]            pipe_data_in,
  input  logic                    pipe_valid,
  input  logic [127:0]            pipe_data_out,
  input  logic                    flush,
  output logic                    flush_done,
  output logic [ID_W+1:0]         in_flight,
  output logic                    tag_err
);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSHED} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     ptr, ptr_next;
  logic [ID_W-1:0]     grant_id, grant_inc, cand;
  logic                grant_any;
  logic                accept;
  logic                issue_valid;
  logic [ID_W-1:0]     issue_id;
  logic [PIPE_LAT-1:0] tag_valid;
  logic [ID_W-1:0]     tag_id [PIPE_LAT];
  logic                head_valid;
  logic [ID_W-1:0]     head_id;
  logic                tagged_resp;
  logic [127:0]        req_word [NUM_REQ];

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || PIPE_LAT < 1 ||
      ID_W != $clog2(NUM_REQ)) begin : g_bad_params
    $error("aes_dec_arbiter: unsupported parameter combination");
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
    assign req_word[gi] = req_data[128*gi +: 128];
  end

  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign grant_inc = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_next = state;
    req_ready  = '0;
    unique case (state)
      RUN: begin
        if (grant_any && rst_n) req_ready[grant_id] = 1'b1;
        if (flush) state_next = DRAIN;
      end
      DRAIN:   if (in_flight == '0) state_next = FLUSHED;
      FLUSHED: if (!flush) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign flush_done = (state == FLUSHED);
  assign accept     = |(req_valid & req_ready);

`ifdef AES_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] burst_cnt, burst_cnt_next;
  logic [ID_W-1:0]  last_id;

  // The pointer parks on the current winner until its burst allowance is used up.
  always_comb begin
    ptr_next       = ptr;
    burst_cnt_next = burst_cnt;
    if (accept) begin
      burst_cnt_next = (grant_id == last_id) ? burst_cnt + 1'b1 : CNT_W'(1);
      if (burst_cnt_next >= CNT_W'(MAX_BURST)) begin
        ptr_next       = grant_inc;
        burst_cnt_next = '0;
      end else begin
        ptr_next = grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      last_id   <= '0;
    end else if (accept) begin
      burst_cnt <= burst_cnt_next;
      last_id   <= grant_id;
    end
  end
`else
  always_comb begin
    ptr_next = ptr;
    if (accept) ptr_next = grant_inc;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      ptr          <= '0;
      issue_valid  <= 1'b0;
      issue_id     <= '0;
      pipe_data_in <= '0;
      in_flight    <= '0;
      tag_err      <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      issue_valid <= accept;
      if (accept) begin
        issue_id     <= grant_id;
        pipe_data_in <= req_word[grant_id];
      end
      tag_err <= tag_err | (pipe_valid & ~head_valid);
      case ({accept, tagged_resp})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: ;
      endcase
    end
  end

  assign pipe_ready = issue_valid;

  // Tags travel alongside the pipe; the last slot lines up with pipe_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_valid[0] <= issue_valid;
      tag_id[0]    <= issue_id;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  assign head_valid  = tag_valid[PIPE_LAT-1];
  assign head_id     = tag_id[PIPE_LAT-1];
  assign tagged_resp = pipe_valid & head_valid;
  assign resp_data   = pipe_data_out;

  always_comb begin
    resp_valid = '0;
    if (tagged_resp) resp_valid[head_id] = 1'b1;
  end

endmodule
